// File: rtl/anc_pkg.sv
// anc_pkg: FSM state type, saturation helper and wide working width shared by the ANC LMS block
package anc_pkg;
  localparam int ACC_W = 64;
  typedef enum logic [2:0] {IDLE, CLR, UPD, WRX, MAC, OUT} state_t;
  function automatic logic signed [ACC_W-1:0] sat_w(input logic signed [ACC_W-1:0] v, input int w);
    logic signed [ACC_W-1:0] hi, lo;
    hi = (ACC_W'(1) <<< (w - 1)) - ACC_W'(1);
    lo = -hi - ACC_W'(1);
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/anc_mac_sat.sv
// anc_mac_sat: one signed multiply feeding a full-precision accumulate and a rescaled saturating add
module anc_mac_sat import anc_pkg::*; #(
  parameter int W = 16,
  parameter int AW = 41
) (
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  input  logic signed [AW-1:0] add,
  output logic signed [AW-1:0] sum,
  output logic signed [W-1:0]  res
);
  logic signed [2*W-1:0] prod;
  logic signed [ACC_W-1:0] scaled;
  // raw product for the FIR accumulator, Q-rescaled and clamped product for weight/step updates
  always_comb begin
    prod = a * b;
    sum = add + AW'(prod);
    scaled = ACC_W'(prod >>> (W - 1)) + ACC_W'(add);
    res = W'(sat_w(scaled, W));
  end
endmodule

// File: rtl/anc_lms_mc.sv
// anc_lms_mc: time-multiplexed multi-channel LMS adaptive FIR with leakage, freeze and weight clear
module anc_lms_mc import anc_pkg::*; #(
  parameter int W = 16,
  parameter int TAPS = 512,
  parameter int M = 9,
  parameter int CH = 2,
  parameter int LEAK_SH = 12,
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] x_in,
  input  logic [CH*W-1:0] e_in,
  input  logic [W-1:0]    mu_in,
  input  logic            adapt_en,
  input  logic            leak_en,
  input  logic            clr_w,
  output logic [W-1:0]    out_sample,
  output logic [CW-1:0]   out_ch,
  output logic            out_valid,
  output logic            busy
);
  localparam int AW = 2 * W + M;
  state_t state;
  logic [CW-1:0] c;
  logic [M-1:0] k;
  logic [M-1:0] ptr [CH];
  logic signed [W-1:0] w_mem [CH*TAPS];
  logic signed [W-1:0] dl_mem [CH*TAPS];
  logic [CH*W-1:0] x_r, e_r;
  logic signed [W-1:0] mu_r, step, wk, xk, leak_v, ma, mb, mres;
  logic signed [AW-1:0] acc, madd, msum;
  logic adapt_r, leak_r, clr_dl, last_k;
  int ci, nc;

  assign in_ready = (state == IDLE) && !clr_w;
  assign busy = state != IDLE;

  // operand steering: IDLE/OUT precompute the next channel's step, UPD adapts, MAC accumulates
  always_comb begin
    ci = int'(c);
    nc = (ci == CH - 1) ? 0 : ci + 1;
    last_k = k == M'(TAPS - 1);
    wk = w_mem[{c, k}];
    xk = dl_mem[{c, M'(ptr[c] - k)}];
    leak_v = leak_r ? (wk >>> LEAK_SH) : W'(0);
    ma = (state == IDLE) ? mu_in : (state == OUT) ? mu_r : (state == UPD) ? step : wk;
    mb = (state == IDLE) ? e_in[W-1:0] : (state == OUT) ? e_r[nc*W +: W] : xk;
    madd = (state == UPD) ? AW'(wk) - AW'(leak_v) : (state == MAC) ? acc : AW'(0);
  end

  anc_mac_sat #(.W(W), .AW(AW)) u_mac (.a(ma), .b(mb), .add(madd), .sum(msum), .res(mres));

  // sequencer, datapath registers and memory writes; reset reuses the clear sweep for both memories
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR;
      c <= '0;
      k <= '0;
      acc <= '0;
      step <= '0;
      clr_dl <= 1'b1;
      out_valid <= 1'b0;
      out_sample <= '0;
      out_ch <= '0;
      for (int i = 0; i < CH; i++) ptr[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (clr_w) begin
          state <= CLR;
          k <= '0;
        end else if (in_valid) begin
          x_r <= x_in;
          e_r <= e_in;
          mu_r <= mu_in;
          adapt_r <= adapt_en;
          leak_r <= leak_en;
          step <= mres;
          c <= '0;
          k <= '0;
          state <= adapt_en ? UPD : WRX;
        end
        CLR: begin
          for (int i = 0; i < CH; i++) begin
            w_mem[{CW'(i), k}] <= '0;
            if (clr_dl) dl_mem[{CW'(i), k}] <= '0;
          end
          k <= k + 1'b1;
          if (last_k) begin
            state <= IDLE;
            clr_dl <= 1'b0;
          end
        end
        UPD: begin
          w_mem[{c, k}] <= mres;
          k <= k + 1'b1;
          if (last_k) state <= WRX;
        end
        WRX: begin
          ptr[c] <= ptr[c] + 1'b1;
          dl_mem[{c, M'(ptr[c] + 1'b1)}] <= x_r[ci*W +: W];
          acc <= '0;
          k <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= msum;
          k <= k + 1'b1;
          if (last_k) begin
            out_valid <= 1'b1;
            out_sample <= W'(sat_w(ACC_W'(msum >>> (W - 1)), W));
            out_ch <= c;
            state <= OUT;
          end
        end
        OUT: begin
          k <= '0;
          step <= mres;
          if (ci == CH - 1) state <= IDLE;
          else begin
            c <= c + 1'b1;
            state <= adapt_r ? UPD : WRX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_anc_lms_mc.sv
// tb_anc_lms_mc: scoreboard bench with a tap-age reference model for the multi-channel LMS ANC
module tb_anc_lms_mc;
  localparam int W = 16, TAPS = 4, M = 2, CH = 2;
  logic clk = 1'b0;
  logic rst, in_valid, clr_w, adapt_en, leak_en;
  logic [CH*W-1:0] x_in, e_in;
  logic [W-1:0] mu_in, out_sample;
  logic [0:0] out_ch;
  logic in_ready, out_valid, busy;
  int checks = 0, errors = 0, cyc = 0;
  longint wm [CH][TAPS];
  longint hist [CH][TAPS];
  logic [W-1:0] exp_val [$];
  int exp_ch [$];
  int strobes [$];
  logic [W-1:0] last_out [CH];
  logic [W-1:0] ev;
  int ec;
  bit prev_v = 1'b0;

  anc_lms_mc #(.W(W), .TAPS(TAPS), .M(M), .CH(CH), .LEAK_SH(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .e_in(e_in),
    .mu_in(mu_in), .adapt_en(adapt_en), .leak_en(leak_en), .clr_w(clr_w), .out_sample(out_sample),
    .out_ch(out_ch), .out_valid(out_valid), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic longint sat(input longint v);
    return (v > 32767) ? 64'sd32767 : (v < -32768) ? -64'sd32768 : v;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < TAPS; t++) begin
        wm[ch][t] = 0;
        hist[ch][t] = 0;
      end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < TAPS; t++) wm[ch][t] = 0;
  endtask

  // hist[ch][t] is the sample t frames old; adaptation sees the line before the new sample arrives
  task automatic model_frame(input logic [CH*W-1:0] x, e, input logic [W-1:0] mu, input bit adapt, leak);
    longint st, acc;
    for (int ch = 0; ch < CH; ch++) begin
      if (adapt) begin
        st = sat((longint'($signed(mu)) * longint'($signed(e[ch*W +: W]))) >>> 15);
        for (int t = 0; t < TAPS; t++)
          wm[ch][t] = sat(wm[ch][t] + ((st * hist[ch][t]) >>> 15) - (leak ? (wm[ch][t] >>> 12) : 64'sd0));
      end
      for (int t = TAPS - 1; t > 0; t--) hist[ch][t] = hist[ch][t-1];
      hist[ch][0] = longint'($signed(x[ch*W +: W]));
      acc = 0;
      for (int t = 0; t < TAPS; t++) acc += wm[ch][t] * hist[ch][t];
      exp_val.push_back(16'(sat(acc >>> 15)));
      exp_ch.push_back(ch);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_bound", 64'(n < 200), 1);
  endtask

  task automatic send(input logic [CH*W-1:0] x, e, input logic [W-1:0] mu, input bit adapt, leak, output int t0);
    int n;
    wait_ready(n);
    x_in = x;
    e_in = e;
    mu_in = mu;
    adapt_en = adapt;
    leak_en = leak;
    in_valid = 1'b1;
    t0 = cyc;
    model_frame(x, e, mu, adapt, leak);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      strobes.push_back(cyc);
      last_out[out_ch] = out_sample;
      checks++;
      if (exp_val.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected ch=%0d got=%h want=no_strobe", out_ch, out_sample);
      end else begin
        ev = exp_val.pop_front();
        ec = exp_ch.pop_front();
        if (out_sample !== ev || int'(out_ch) != ec) begin
          errors++;
          $display("FAIL out_sample got=ch%0d:%h want=ch%0d:%h", out_ch, out_sample, ec, ev);
        end
      end
      checks++;
      if (prev_v) begin
        errors++;
        $display("FAIL strobe_gap got=back_to_back want=gap");
      end
    end
    prev_v = !rst && out_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, n;
    logic [CH*W-1:0] xr, er;
    rst = 1'b1; in_valid = 1'b0; clr_w = 1'b0; x_in = '0; e_in = '0; mu_in = '0; adapt_en = 1'b0; leak_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_busy", busy, 1);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    wait_ready(n);
    chk("init_sweep", n, 4);
    chk("idle_busy", busy, 0);
    strobes.delete();
    send({2{16'h4000}}, '0, 16'h7FFF, 1'b1, 1'b0, t0);
    wait_ready(n);
    chk("adapt_period", cyc - t0, 21);
    chk("adapt_strobes", strobes.size(), 2);
    if (strobes.size() == 2) begin
      chk("ch0_latency", strobes[0] - t0, 10);
      chk("ch1_latency", strobes[1] - t0, 20);
    end
    chk("impulse_out0", last_out[0], 0);
    chk("impulse_out1", last_out[1], 0);
    x_in = {16'h1234, 16'h4321}; e_in = {2{16'h7000}}; mu_in = 16'h7FFF; adapt_en = 1'b1;
    in_valid = 1'b1;
    clr_w = 1'b1;
    #1;
    chk("clr_blocks_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_w = 1'b0;
    wait_ready(n);
    chk("clr_sweep", n, 4);
    model_clear();
    send({2{16'h4000}}, '0, 16'h7FFF, 1'b1, 1'b0, t0);
    send('0, {2{16'h4000}}, 16'h7FFF, 1'b1, 1'b0, t0);
    send({2{16'h4000}}, '0, 16'h0000, 1'b1, 1'b0, t0);
    wait_ready(n);
    chk("filter_w0_ch0", last_out[0], 16'h0FFF);
    chk("filter_w0_ch1", last_out[1], 16'h0FFF);
    repeat (4) send({2{16'h7FFF}}, {2{16'h7FFF}}, 16'h7FFF, 1'b1, 1'b0, t0);
    wait_ready(n);
    strobes.delete();
    xr = $urandom;
    er = $urandom;
    send(xr, er, 16'($urandom), 1'b0, 1'b0, t0);
    wait_ready(n);
    chk("freeze_period", cyc - t0, 13);
    chk("freeze_strobes", strobes.size(), 2);
    if (strobes.size() == 2) begin
      chk("freeze_ch0_latency", strobes[0] - t0, 6);
      chk("freeze_ch1_latency", strobes[1] - t0, 12);
    end
    repeat (3) send(CH*W'($urandom), '0, 16'($urandom), 1'b1, 1'b1, t0);
    send({2{16'h4000}}, {2{16'h2000}}, 16'h4000, 1'b1, 1'b0, t0);
    while (cyc < t0 + 17) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_pending", exp_val.size(), 1);
    exp_val.delete();
    exp_ch.delete();
    model_reset();
    wait_ready(n);
    chk("rst_sweep", n, 4);
    send({2{16'h4000}}, '0, 16'h7FFF, 1'b1, 1'b0, t0);
    wait_ready(n);
    chk("post_rst_out0", last_out[0], 0);
    chk("post_rst_out1", last_out[1], 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        wait_ready(n);
        clr_w = 1'b1;
        @(posedge clk);
        #1;
        clr_w = 1'b0;
        model_clear();
      end
      xr = $urandom;
      er = $urandom;
      send(xr, er, 16'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), t0);
    end
    wait_ready(n);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", exp_val.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
